openofdm_rx_watchdog_mc: RTL and testbench

Parametrised successor to the receiver SIGNAL watchdog in the OpenOFDM receive path. It runs four independently enabled monitors: DC offset, SIGNAL length, equalizer collapse and demodulation timeout. It drives a stretched `receiver_rst` into the dot11 core, enforces a configurable hold-off after every reset, and exposes a sticky cause mask plus per-cause saturating event counters for the AXI status registers.

---
 rtl/openofdm_rx_watchdog_mc.sv | 194 +++++++++++++++++++
 tb/tb_openofdm_rx_watchdog_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/openofdm_rx_watchdog_mc.sv
// Receiver watchdog: four independently enabled monitors (DC, SIGNAL length, equalizer
// collapse, demod timeout) drive a stretched receiver reset with hold-off and event stats.
module openofdm_rx_watchdog_mc #(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int DC_WIN_LOG2   = 5,
  parameter int TIMEOUT_WIDTH = 20,
  parameter int CNT_WIDTH     = 16,
  parameter int RST_HOLD      = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable,
  input  logic [IQ_DATA_WIDTH-1:0]   i_data,
  input  logic [IQ_DATA_WIDTH-1:0]   q_data,
  input  logic                       iq_valid,
  input  logic                       power_trigger,
  input  logic [15:0]                signal_len,
  input  logic                       sig_valid,
  input  logic                       demod_is_ongoing,
  input  logic [2*IQ_DATA_WIDTH-1:0] equalizer,
  input  logic                       equalizer_valid,
  input  logic [3:0]                 cause_en,
  input  logic [7:0]                 dc_th,
  input  logic [15:0]                min_len_th,
  input  logic [15:0]                max_len_th,
  input  logic [IQ_DATA_WIDTH-1:0]   small_mag_th,
  input  logic [5:0]                 small_cnt_th,
  input  logic [TIMEOUT_WIDTH-1:0]   timeout_th,
  input  logic [7:0]                 holdoff_len,
  input  logic                       cnt_clear,
  output logic                       receiver_rst,
  output logic [3:0]                 rst_cause,
  output logic [4*CNT_WIDTH-1:0]     event_cnt
);

  localparam int ACC_W = IQ_DATA_WIDTH + DC_WIN_LOG2;
  localparam int PH_W  = ($clog2(RST_HOLD + 1) > 8) ? $clog2(RST_HOLD + 1) : 8;

  typedef enum logic [1:0] {S_MON, S_RST, S_HOLDOFF} state_t;

  // One extra bit so the most negative sample has a representable magnitude.
  function automatic logic [IQ_DATA_WIDTH:0] absVal(input logic [IQ_DATA_WIDTH-1:0] v);
    logic [IQ_DATA_WIDTH:0] e;
    e = {v[IQ_DATA_WIDTH-1], v};
    return e[IQ_DATA_WIDTH] ? ((~e) + (IQ_DATA_WIDTH + 1)'(1)) : e;
  endfunction

  state_t                   r_state;
  logic [PH_W-1:0]          r_phase;
  logic                     r_rst;
  logic signed [ACC_W-1:0]  r_accI;
  logic signed [ACC_W-1:0]  r_accQ;
  logic [DC_WIN_LOG2-1:0]   r_dcCnt;
  logic [5:0]               r_eqRun;
  logic [TIMEOUT_WIDTH-1:0] r_toCnt;
  logic [3:0]               r_cause;
  logic [CNT_WIDTH-1:0]     r_evCnt [4];

  logic                     w_mon;
  logic                     w_dcQual;
  logic                     w_dcLast;
  logic signed [ACC_W-1:0]  w_sumI;
  logic signed [ACC_W-1:0]  w_sumQ;
  logic [IQ_DATA_WIDTH-1:0] w_meanI;
  logic [IQ_DATA_WIDTH-1:0] w_meanQ;
  logic [IQ_DATA_WIDTH:0]   w_dcThExt;
  logic [IQ_DATA_WIDTH:0]   w_smallTh;
  logic                     w_eqSmall;
  logic [5:0]               w_eqRunNext;
  logic                     w_dcTrig;
  logic                     w_lenTrig;
  logic                     w_eqTrig;
  logic                     w_toTrig;
  logic [3:0]               w_trig;
  logic                     w_any;

  assign w_mon    = (r_state == S_MON);
  assign w_dcQual = enable & power_trigger & cause_en[0];
  assign w_dcLast = &r_dcCnt;
  assign w_sumI   = r_accI + {{DC_WIN_LOG2{i_data[IQ_DATA_WIDTH-1]}}, i_data};
  assign w_sumQ   = r_accQ + {{DC_WIN_LOG2{q_data[IQ_DATA_WIDTH-1]}}, q_data};
  // The upper slice of the window sum is exactly the arithmetic shift by DC_WIN_LOG2.
  assign w_meanI   = w_sumI[ACC_W-1:DC_WIN_LOG2];
  assign w_meanQ   = w_sumQ[ACC_W-1:DC_WIN_LOG2];
  assign w_dcThExt = {{(IQ_DATA_WIDTH - 7){1'b0}}, dc_th};
  assign w_dcTrig  = w_dcQual & iq_valid & w_dcLast &
                     ((absVal(w_meanI) > w_dcThExt) | (absVal(w_meanQ) > w_dcThExt));

  assign w_lenTrig = enable & cause_en[1] & sig_valid &
                     ((signal_len < min_len_th) | (signal_len > max_len_th));

  assign w_smallTh   = {1'b0, small_mag_th};
  assign w_eqSmall   = (absVal(equalizer[2*IQ_DATA_WIDTH-1:IQ_DATA_WIDTH]) < w_smallTh) &&
                       (absVal(equalizer[IQ_DATA_WIDTH-1:0]) < w_smallTh);
  assign w_eqRunNext = !w_eqSmall ? 6'd0 : ((&r_eqRun) ? r_eqRun : r_eqRun + 6'd1);
  assign w_eqTrig    = cause_en[2] & equalizer_valid & (small_cnt_th != 6'd0) &
                       w_eqSmall & (w_eqRunNext >= small_cnt_th);

  assign w_toTrig = cause_en[3] & demod_is_ongoing & (timeout_th != '0) &
                    (r_toCnt == timeout_th);

  assign w_trig = {w_toTrig, w_eqTrig, w_lenTrig, w_dcTrig} & {4{w_mon}};
  assign w_any  = |w_trig;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_MON;
      r_phase <= '0;
      r_rst   <= 1'b0;
    end else begin
      case (r_state)
        S_MON: begin
          if (w_any) begin
            r_state <= S_RST;
            r_phase <= '0;
            r_rst   <= 1'b1;
          end
        end
        S_RST: begin
          if (r_phase == PH_W'(RST_HOLD - 1)) begin
            r_rst   <= 1'b0;
            r_phase <= '0;
            r_state <= (holdoff_len == 8'd0) ? S_MON : S_HOLDOFF;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        S_HOLDOFF: begin
          // >= rather than == so a threshold lowered mid hold-off cannot strand the FSM.
          if ((r_phase + PH_W'(1)) >= PH_W'(holdoff_len)) begin
            r_phase <= '0;
            r_state <= S_MON;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        default: begin
          r_state <= S_MON;
          r_phase <= '0;
          r_rst   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_accI  <= '0;
      r_accQ  <= '0;
      r_dcCnt <= '0;
    end else if (!w_mon || !w_dcQual || (iq_valid && w_dcLast)) begin
      r_accI  <= '0;
      r_accQ  <= '0;
      r_dcCnt <= '0;
    end else if (iq_valid) begin
      r_accI  <= w_sumI;
      r_accQ  <= w_sumQ;
      r_dcCnt <= r_dcCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_eqRun <= '0;
      r_toCnt <= '0;
    end else begin
      if (!w_mon || !cause_en[2]) r_eqRun <= '0;
      else if (equalizer_valid)   r_eqRun <= w_eqRunNext;

      if (!w_mon || !cause_en[3] || !demod_is_ongoing) r_toCnt <= '0;
      else if (!(&r_toCnt))                            r_toCnt <= r_toCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cause <= '0;
      for (int i = 0; i < 4; i++) r_evCnt[i] <= '0;
    end else if (cnt_clear) begin
      r_cause <= '0;
      for (int i = 0; i < 4; i++) r_evCnt[i] <= '0;
    end else begin
      if (w_any) r_cause <= w_trig;
      for (int i = 0; i < 4; i++) begin
        if (w_trig[i] && !(&r_evCnt[i])) r_evCnt[i] <= r_evCnt[i] + 1'b1;
      end
    end
  end

  assign receiver_rst = r_rst;
  assign rst_cause    = r_cause;
  assign event_cnt    = {r_evCnt[3], r_evCnt[2], r_evCnt[1], r_evCnt[0]};

endmodule

// File: tb/tb_openofdm_rx_watchdog_mc.sv
// Directed bench for openofdm_rx_watchdog_mc; counters built 4 bits wide so
// saturation is reachable in a few hundred cycles.
module tb_openofdm_rx_watchdog_mc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [15:0] iData;
  logic [15:0] qData;
  logic        iqValid;
  logic        powerTrigger;
  logic [15:0] signalLen;
  logic        sigValid;
  logic        demodOngoing;
  logic [31:0] equalizer;
  logic        equalizerValid;
  logic [3:0]  causeEn;
  logic [7:0]  dcTh;
  logic [15:0] minLenTh;
  logic [15:0] maxLenTh;
  logic [15:0] smallMagTh;
  logic [5:0]  smallCntTh;
  logic [19:0] timeoutTh;
  logic [7:0]  holdoffLen;
  logic        cntClear;
  logic        receiverRst;
  logic [3:0]  rstCause;
  logic [15:0] eventCnt;

  int checks   = 0;
  int failures = 0;

  openofdm_rx_watchdog_mc #(
    .IQ_DATA_WIDTH(16), .DC_WIN_LOG2(5), .TIMEOUT_WIDTH(20), .CNT_WIDTH(4), .RST_HOLD(4)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .i_data(iData), .q_data(qData),
    .iq_valid(iqValid), .power_trigger(powerTrigger), .signal_len(signalLen),
    .sig_valid(sigValid), .demod_is_ongoing(demodOngoing), .equalizer(equalizer),
    .equalizer_valid(equalizerValid), .cause_en(causeEn), .dc_th(dcTh),
    .min_len_th(minLenTh), .max_len_th(maxLenTh), .small_mag_th(smallMagTh),
    .small_cnt_th(smallCntTh), .timeout_th(timeoutTh), .holdoff_len(holdoffLen),
    .cnt_clear(cntClear), .receiver_rst(receiverRst), .rst_cause(rstCause),
    .event_cnt(eventCnt)
  );

  always #5 clk = ~clk;

  // Advance n cycles; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Expects receiver_rst high now and for 3 more cycles, then low.
  task automatic checkPulse(input string tag);
    for (int k = 0; k < 4; k++) begin
      checkOutput({tag, "_hi"}, 64'(receiverRst), 64'd1);
      applyStimulus(1);
    end
    checkOutput({tag, "_lo"}, 64'(receiverRst), 64'd0);
  endtask

  task automatic lenPulse(input logic [15:0] len);
    signalLen = len;
    sigValid  = 1'b1;
    applyStimulus(1);
    sigValid  = 1'b0;
  endtask

  logic [31:0] eqSeq [12];
  logic        quiet;
  int          waitCycles;
  logic        seen;

  initial begin
    rstn = 1'b0; enable = 1'b1; iData = '0; qData = '0; iqValid = 1'b0;
    powerTrigger = 1'b0; signalLen = '0; sigValid = 1'b0; demodOngoing = 1'b0;
    equalizer = '0; equalizerValid = 1'b0; causeEn = 4'hF; dcTh = 8'd10;
    minLenTh = 16'd14; maxLenTh = 16'd1600; smallMagTh = 16'd8; smallCntTh = 6'd6;
    timeoutTh = 20'd100; holdoffLen = 8'd0; cntClear = 1'b0;

    applyStimulus(2);
    checkOutput("reset_rst", 64'(receiverRst), 64'd0);
    checkOutput("reset_cause", 64'(rstCause), 64'd0);
    checkOutput("reset_cnt", 64'(eventCnt), 64'd0);
    rstn = 1'b1;
    applyStimulus(1);

    // DC: 32 samples of I=+20 give mean 20 > 10
    powerTrigger = 1'b1; iqValid = 1'b1; iData = 16'd20; qData = 16'd0;
    applyStimulus(31);
    checkOutput("dc_early", 64'(receiverRst), 64'd0);
    applyStimulus(1);
    iqValid = 1'b0; powerTrigger = 1'b0;
    checkOutput("dc_cause", 64'(rstCause), 64'h1);
    checkOutput("dc_cnt", 64'(eventCnt), 64'h0001);
    checkPulse("dc");

    // DC boundary: mean of -10 equals threshold, no reset
    powerTrigger = 1'b1; iqValid = 1'b1; iData = 16'hFFF6; quiet = 1'b0;
    for (int k = 0; k < 33; k++) begin
      applyStimulus(1);
      quiet |= receiverRst;
    end
    iqValid = 1'b0; powerTrigger = 1'b0; iData = '0;
    checkOutput("dc_at_th", 64'(quiet), 64'd0);

    // LEN: 5 < 14 triggers, 100 in range does not
    lenPulse(16'd5);
    checkOutput("len_cause", 64'(rstCause), 64'h2);
    checkOutput("len_cnt", 64'(eventCnt), 64'h0011);
    checkPulse("len");
    lenPulse(16'd100);
    checkOutput("len_ok_a", 64'(receiverRst), 64'd0);
    applyStimulus(1);
    checkOutput("len_ok_b", 64'(receiverRst), 64'd0);
    checkOutput("len_ok_cause", 64'(rstCause), 64'h2);

    // EQ: 5 small, 1 large (|I|=8 not < 8), 6 small
    for (int k = 0; k < 12; k++) eqSeq[k] = (k == 5) ? 32'hFFF8_0000 : 32'h0003_FFFE;
    quiet = 1'b0;
    for (int k = 0; k < 12; k++) begin
      equalizer = eqSeq[k]; equalizerValid = 1'b1;
      applyStimulus(1);
      if (k < 11) quiet |= receiverRst;
    end
    equalizerValid = 1'b0;
    checkOutput("eq_early", 64'(quiet), 64'd0);
    checkOutput("eq_cause", 64'(rstCause), 64'h4);
    checkOutput("eq_cnt", 64'(eventCnt), 64'h0111);
    checkPulse("eq");

    // TO with hold-off 20; LEN violations during hold-off ignored
    holdoffLen = 8'd20;
    demodOngoing = 1'b1; waitCycles = 0; seen = 1'b0;
    while (!seen && waitCycles < 200) begin
      applyStimulus(1);
      waitCycles++;
      if (receiverRst) seen = 1'b1;
    end
    demodOngoing = 1'b0;
    checkOutput("to_latency", 64'(waitCycles), 64'd101);
    checkOutput("to_cause", 64'(rstCause), 64'h8);
    checkPulse("to");
    signalLen = 16'd5; sigValid = 1'b1; quiet = 1'b0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1);
      quiet |= receiverRst;
    end
    checkOutput("holdoff_ignore", 64'(quiet), 64'd0);
    checkOutput("holdoff_cnt", 64'(eventCnt), 64'h1111);
    applyStimulus(1);
    sigValid = 1'b0; holdoffLen = 8'd0;
    checkOutput("holdoff_accept", 64'(receiverRst), 64'd1);
    checkOutput("holdoff_acc_cnt", 64'(eventCnt), 64'h1121);
    checkPulse("holdoff_acc");

    // Simultaneous DC (mean Q=-30) and LEN (2000 > 1600)
    powerTrigger = 1'b1; iqValid = 1'b1; iData = 16'd0; qData = 16'hFFE2;
    applyStimulus(31);
    signalLen = 16'd2000; sigValid = 1'b1;
    applyStimulus(1);
    sigValid = 1'b0; iqValid = 1'b0; powerTrigger = 1'b0; qData = '0;
    checkOutput("both_cause", 64'(rstCause), 64'h3);
    checkOutput("both_cnt", 64'(eventCnt), 64'h1132);
    checkPulse("both");

    // Saturation of the LEN counter at 15
    for (int k = 0; k < 12; k++) begin
      lenPulse(16'd5);
      applyStimulus(4);
    end
    checkOutput("sat_reach", 64'(eventCnt), 64'h11F2);
    lenPulse(16'd5);
    checkOutput("sat_rst", 64'(receiverRst), 64'd1);
    checkOutput("sat_hold", 64'(eventCnt), 64'h11F2);
    applyStimulus(4);

    // cnt_clear beats a same-cycle trigger
    cntClear = 1'b1;
    lenPulse(16'd5);
    cntClear = 1'b0;
    checkOutput("clr_rst", 64'(receiverRst), 64'd1);
    checkOutput("clr_cnt", 64'(eventCnt), 64'd0);
    checkOutput("clr_cause", 64'(rstCause), 64'd0);
    applyStimulus(4);

    // LEN monitor disabled by cause_en
    causeEn = 4'b1101;
    lenPulse(16'd5);
    checkOutput("len_dis", 64'(receiverRst), 64'd0);
    causeEn = 4'hF;
    applyStimulus(1);

    // Async reset in the middle of S_RST
    lenPulse(16'd5);
    checkOutput("arst_pre", 64'(receiverRst), 64'd1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("arst_rst", 64'(receiverRst), 64'd0);
    checkOutput("arst_cause", 64'(rstCause), 64'd0);
    checkOutput("arst_cnt", 64'(eventCnt), 64'd0);
    applyStimulus(2);
    rstn = 1'b1;
    applyStimulus(1);
    lenPulse(16'd5);
    checkPulse("post_arst");
    checkOutput("post_arst_cause", 64'(rstCause), 64'h2);
    checkOutput("post_arst_cnt", 64'(eventCnt), 64'h0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 0x1 expected 0x0");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
